// File: rtl/tpg_arbiter.sv
// Round-robin arbiter merging NUM_REQ traffic-generator flit streams onto one NoC ingress port.
// Each winner may push up to BURST flits through a single registered output stage; forwarded flits are counted.
module tpg_arbiter #(
  parameter int WIDTH     = 32,
  parameter int NUM_REQ   = 4,
  parameter int BURST     = 4,
  parameter int NUM_TESTS = 1000,
  localparam int IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       valid_in,
  input  logic [NUM_REQ*WIDTH-1:0] data_in,
  output logic [NUM_REQ-1:0]       ready_out,
  output logic [WIDTH-1:0]         data_out,
  output logic                     valid_out,
  input  logic                     ready_in,
  output logic [IDX_W-1:0]         grant_idx,
  output logic                     done
);
  localparam int CNT_W = $clog2(BURST + 1);
  localparam logic [0:0]       S_IDLE     = 1'b0;
  localparam logic [0:0]       S_GRANT    = 1'b1;
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_REQ - 1);
  localparam logic [31:0]      FWD_TARGET = 32'(NUM_TESTS);

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [CNT_W-1:0] burst_q, burst_d;
  logic             vld_q, vld_d;
  logic [WIDTH-1:0] dat_q, dat_d;
  logic [31:0]      fwd_q, fwd_d;
  logic             done_q, done_d;

  logic [IDX_W-1:0] sel_idx;
  logic             gnt_vld;
  logic             out_rdy;
  logic             xfer;

  // Downward scan so the lowest rotation offset from rr_q wins.
  always_comb begin
    sel_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (valid_in[(int'(rr_q) + k) % NUM_REQ]) begin
        sel_idx = IDX_W'((int'(rr_q) + k) % NUM_REQ);
      end
    end
  end

  assign gnt_vld = valid_in[grant_q];
  assign out_rdy = !vld_q || ready_in;
  assign xfer    = (state_q == S_GRANT) && gnt_vld && out_rdy;

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    grant_d   = grant_q;
    burst_d   = burst_q;
    ready_out = '0;
    case (state_q)
      S_IDLE: begin
        if (|valid_in) begin
          grant_d = sel_idx;
          burst_d = '0;
          state_d = S_GRANT;
        end
      end
      default: begin
        if (!rst) ready_out[grant_q] = out_rdy;
        if (xfer) burst_d = burst_q + 1'b1;
        if ((xfer && burst_q == BURST_LAST) || !gnt_vld) begin
          state_d = S_IDLE;
          rr_d    = (grant_q == IDX_LAST) ? '0 : grant_q + 1'b1;
        end
      end
    endcase
  end

  // Output register: load on transfer, otherwise drain when the router accepts.
  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (xfer) begin
      vld_d = 1'b1;
      dat_d = data_in[int'(grant_q) * WIDTH +: WIDTH];
    end else if (ready_in) begin
      vld_d = 1'b0;
    end
  end

  always_comb begin
    fwd_d = fwd_q;
    if (vld_q && ready_in && fwd_q != '1) fwd_d = fwd_q + 32'd1;
    done_d = done_q || (fwd_d == FWD_TARGET);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      grant_q <= '0;
      burst_q <= '0;
      vld_q   <= 1'b0;
      dat_q   <= '0;
      fwd_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      burst_q <= burst_d;
      vld_q   <= vld_d;
      dat_q   <= dat_d;
      fwd_q   <= fwd_d;
      done_q  <= done_d;
    end
  end

  assign data_out  = dat_q;
  assign valid_out = vld_q;
  assign grant_idx = grant_q;
  assign done      = done_q;

endmodule

// File: tb/tb_tpg_arbiter.sv
// Directed and randomized bench for tpg_arbiter with 4 requesters, BURST=4, NUM_TESTS=10.
// Requester i emits flits 0xA0ii_ssss where s is its own running sequence number.
module tb_tpg_arbiter;
  localparam int W  = 32;
  localparam int N  = 4;
  localparam int B  = 4;
  localparam int NT = 10;

  logic         clk;
  logic         rst;
  logic [N-1:0] valid_in;
  logic [N*W-1:0] data_in;
  logic [N-1:0] ready_out;
  logic [W-1:0] data_out;
  logic         valid_out;
  logic         ready_in;
  logic [1:0]   grant_idx;
  logic         done;

  int checks;
  int failures;
  int seq[N];

  // Values sampled just before each rising edge.
  logic [N-1:0] hs_s;
  logic [N-1:0] vin_s;
  logic         rin_s;
  logic         ohs;
  logic [W-1:0] odat;
  logic [W-1:0] idat;

  tpg_arbiter #(.WIDTH(W), .NUM_REQ(N), .BURST(B), .NUM_TESTS(NT)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in),
    .ready_out(ready_out), .data_out(data_out), .valid_out(valid_out),
    .ready_in(ready_in), .grant_idx(grant_idx), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] flit(input int i, input int s);
    return 32'hA000_0000 | (32'(i) << 16) | 32'(s & 16'hFFFF);
  endfunction

  task automatic set_data();
    for (int i = 0; i < N; i++) data_in[i*W +: W] = flit(i, seq[i]);
  endtask

  // One clock: sample handshakes before the edge, advance source sequences after it.
  task automatic tick();
    @(negedge clk);
    hs_s  = valid_in & ready_out;
    vin_s = valid_in;
    rin_s = ready_in;
    ohs   = valid_out && ready_in;
    odat  = data_out;
    idat  = '0;
    for (int i = 0; i < N; i++) if (hs_s[i]) idat = data_in[i*W +: W];
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (hs_s[i]) seq[i]++;
    set_data();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    valid_in = '0;
    ready_in = 1'b1;
    for (int i = 0; i < N; i++) seq[i] = 0;
    set_data();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    valid_in = '1;
    ready_in = 1'b1;
    set_data();
    tick();
    tick();
    checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid_out: got %b expected 0", valid_out); end
    checks++; if (data_out !== 32'h0) begin failures++; $display("FAIL reset_data_out: got %h expected 0", data_out); end
    checks++; if (grant_idx !== 2'd0) begin failures++; $display("FAIL reset_grant_idx: got %0d expected 0", grant_idx); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (ready_out !== 4'b0000) begin failures++; $display("FAIL reset_ready_out: got %b expected 0000", ready_out); end
  endtask

  task automatic test_round_robin();
    int j, m, eg;
    do_reset();
    valid_in = 4'b1111;
    for (int k = 1; k <= 22; k++) begin
      tick();
      j = (k - 1) / 5;
      m = (k - 1) % 5;
      eg = j % 4;
      checks++;
      if (grant_idx !== 2'(eg)) begin failures++; $display("FAIL rr_grant k=%0d: got %0d expected %0d", k, grant_idx, eg); end
      if (m == 0) begin
        checks++;
        if (valid_out !== 1'b0) begin failures++; $display("FAIL rr_bubble k=%0d: got %b expected 0", k, valid_out); end
        checks++;
        if (ready_out !== 4'(1 << eg)) begin failures++; $display("FAIL rr_ready k=%0d: got %b expected %b", k, ready_out, 4'(1 << eg)); end
      end else begin
        checks++;
        if (valid_out !== 1'b1 || data_out !== flit(eg, 4 * (j / 4) + m - 1))
          begin failures++; $display("FAIL rr_flit k=%0d: got %b/%h expected 1/%h", k, valid_out, data_out, flit(eg, 4 * (j / 4) + m - 1)); end
        if (m == 4) begin
          checks++;
          if (ready_out !== 4'b0000) begin failures++; $display("FAIL rr_idle_ready k=%0d: got %b expected 0000", k, ready_out); end
        end
      end
    end
  endtask

  task automatic test_single_drop();
    do_reset();
    valid_in = 4'b0100;
    tick();
    checks++; if (grant_idx !== 2'd2) begin failures++; $display("FAIL single_grant: got %0d expected 2", grant_idx); end
    tick();
    checks++; if (valid_out !== 1'b1 || data_out !== flit(2, 0)) begin failures++; $display("FAIL single_flit0: got %b/%h expected 1/%h", valid_out, data_out, flit(2, 0)); end
    tick();
    checks++; if (valid_out !== 1'b1 || data_out !== flit(2, 1)) begin failures++; $display("FAIL single_flit1: got %b/%h expected 1/%h", valid_out, data_out, flit(2, 1)); end
    valid_in = 4'b0000;
    tick();
    checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL single_end: got %b expected 0", valid_out); end
    checks++; if (grant_idx !== 2'd2) begin failures++; $display("FAIL single_last_grant: got %0d expected 2", grant_idx); end
    valid_in = 4'b1010;
    tick();
    checks++; if (grant_idx !== 2'd3) begin failures++; $display("FAIL single_next_grant: got %0d expected 3", grant_idx); end
    tick();
    checks++; if (valid_out !== 1'b1 || data_out !== flit(3, 0)) begin failures++; $display("FAIL single_next_flit: got %b/%h expected 1/%h", valid_out, data_out, flit(3, 0)); end
  endtask

  task automatic test_backpressure();
    do_reset();
    valid_in = 4'b0001;
    tick();
    tick();
    tick();
    checks++; if (data_out !== flit(0, 1)) begin failures++; $display("FAIL bp_pre: got %h expected %h", data_out, flit(0, 1)); end
    ready_in = 1'b0;
    #1;
    checks++; if (ready_out !== 4'b0000) begin failures++; $display("FAIL bp_ready_drop: got %b expected 0000", ready_out); end
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (valid_out !== 1'b1 || data_out !== flit(0, 1) || ready_out !== 4'b0000)
        begin failures++; $display("FAIL bp_hold c=%0d: got %b/%h/%b expected 1/%h/0000", c, valid_out, data_out, ready_out, flit(0, 1)); end
    end
    ready_in = 1'b1;
    tick();
    checks++; if (valid_out !== 1'b1 || data_out !== flit(0, 2)) begin failures++; $display("FAIL bp_resume: got %b/%h expected 1/%h", valid_out, data_out, flit(0, 2)); end
    tick();
    checks++; if (data_out !== flit(0, 3)) begin failures++; $display("FAIL bp_last: got %h expected %h", data_out, flit(0, 3)); end
    tick();
    checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL bp_bubble: got %b expected 0", valid_out); end
    tick();
    checks++; if (valid_out !== 1'b1 || data_out !== flit(0, 4)) begin failures++; $display("FAIL bp_next_burst: got %b/%h expected 1/%h", valid_out, data_out, flit(0, 4)); end
  endtask

  task automatic test_done();
    do_reset();
    valid_in = 4'b0001;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 1 || k == 13) begin
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL done_early k=%0d: got %b expected 0", k, done); end
      end
      if (k == 14) begin
        checks++;
        if (done !== 1'b1) begin failures++; $display("FAIL done_rise: got %b expected 1", done); end
      end
    end
    valid_in = 4'b0000;
    tick();
    tick();
    tick();
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL done_sticky: got %b expected 1", done); end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    valid_in = 4'b1111;
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    checks++; if (ready_out !== 4'b0000) begin failures++; $display("FAIL mid_rst_ready: got %b expected 0000", ready_out); end
    tick();
    checks++;
    if (valid_out !== 1'b0 || done !== 1'b0 || grant_idx !== 2'd0 || data_out !== 32'h0)
      begin failures++; $display("FAIL mid_rst_state: got vo=%b done=%b g=%0d d=%h expected 0/0/0/0", valid_out, done, grant_idx, data_out); end
    rst = 1'b0;
    valid_in = 4'b0110;
    tick();
    checks++; if (grant_idx !== 2'd1) begin failures++; $display("FAIL mid_rst_grant: got %0d expected 1", grant_idx); end
    tick();
    checks++; if (valid_out !== 1'b1 || data_out !== flit(1, 0)) begin failures++; $display("FAIL mid_rst_flit: got %b/%h expected 1/%h", valid_out, data_out, flit(1, 0)); end
  endtask

  task automatic test_random();
    logic [W-1:0] sb[$];
    logic [W-1:0] exp_d;
    int wait_cnt[N];
    int max_wait;
    max_wait = 0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    do_reset();
    for (int cyc = 0; cyc < 3004; cyc++) begin
      tick();
      if (ohs) begin
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL rand_extra_flit cyc=%0d: got %h expected none", cyc, odat);
        end else begin
          exp_d = sb.pop_front();
          if (odat !== exp_d) begin failures++; $display("FAIL rand_order cyc=%0d: got %h expected %h", cyc, odat, exp_d); end
        end
      end
      if (|hs_s) sb.push_back(idat);
      for (int i = 0; i < N; i++) begin
        if (hs_s[i]) wait_cnt[i] = 0;
        else if (vin_s[i] && rin_s) wait_cnt[i]++;
        if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
      end
      if (cyc < 3000) begin
        for (int i = 0; i < N; i++) begin
          if (hs_s[i]) valid_in[i] = 1'($urandom_range(0, 1));
          else if (!valid_in[i]) valid_in[i] = ($urandom_range(0, 3) == 0);
        end
        ready_in = ($urandom_range(0, 3) != 0);
      end else begin
        valid_in = '0;
        ready_in = 1'b1;
      end
    end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL rand_lost_flits: got %0d pending expected 0", sb.size()); end
    checks++; if (max_wait > N * (B + 1)) begin failures++; $display("FAIL rand_fairness: got wait %0d expected <= %0d", max_wait, N * (B + 1)); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    valid_in = '0;
    ready_in = 1'b1;
    for (int i = 0; i < N; i++) seq[i] = 0;
    set_data();
    test_reset();
    test_round_robin();
    test_single_drop();
    test_backpressure();
    test_done();
    test_reset_mid_burst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
